flexbex_mem_arbiter: RTL and testbench



---
 rtl/flexbex_mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_flexbex_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flexbex_mem_arbiter.sv
// -----------------------------------------------------------------------------
// flexbex_mem_arbiter
//
// Shares one req/gnt/rvalid memory port between the flexbex instruction fetch
// port and data port. Round-robin arbitration, word-aligned address
// forwarding, a single outstanding transaction, response routing back to the
// requester that owns the transaction, and a response watchdog that forces
// an error response when memory never answers.
//
// Handshake: a requester raises req with stable fields and holds them until
// it sees gnt in the same cycle (gnt is a combinational pass-through of
// mem_gnt_i). After a grant, exactly one rvalid pulse returns to the same
// requester, either the memory's response or a watchdog error response.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles from grant to forced error response (0 = off)
//   TO_WIDTH        watchdog counter width, 2**TO_WIDTH > TIMEOUT_CYCLES
//   ERR_RDATA       rdata returned with an error response
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   instr_*                 fetch port: req/addr in, gnt/rvalid/rdata/err out
//   data_*                  data port: req/we/be/addr/wdata in,
//                           gnt/rvalid/rdata/err out
//   mem_*                   shared memory port: req/we/be/addr/wdata out,
//                           gnt/rvalid/rdata in
//   busy_o                  transaction in flight (state not IDLE)
// -----------------------------------------------------------------------------
module flexbex_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TO_WIDTH       = 8,
   parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, HOLD, RESP} state_e;
   typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} src_e;

   // Last watchdog count before the forced error response.
   localparam logic [TO_WIDTH-1:0] WD_LAST =
      TO_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_e              state_q, state_d;
   src_e                owner_q, owner_d;
   src_e                prefer_q, prefer_d;
   logic [TO_WIDTH-1:0] wd_q, wd_d;

   src_e                sel;
   logic                sel_valid;
   logic                resp_valid;
   logic                resp_err;
   logic [31:0]         resp_rdata;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         owner_q  <= SRC_INSTR;
         prefer_q <= SRC_INSTR;
         wd_q     <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         prefer_q <= prefer_d;
         wd_q     <= wd_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      prefer_d       = prefer_q;
      wd_d           = wd_q;
      sel            = owner_q;
      sel_valid      = 1'b0;
      resp_valid     = 1'b0;
      resp_err       = 1'b0;
      resp_rdata     = '0;
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_be_o       = '0;
      mem_addr_o     = '0;
      mem_wdata_o    = '0;
      instr_gnt_o    = 1'b0;
      data_gnt_o     = 1'b0;
      instr_rvalid_o = 1'b0;
      instr_rdata_o  = '0;
      instr_err_o    = 1'b0;
      data_rvalid_o  = 1'b0;
      data_rdata_o   = '0;
      data_err_o     = 1'b0;

      case (state_q)
         IDLE: begin
            if (instr_req_i && data_req_i) begin
               sel_valid = 1'b1;
               sel       = prefer_q;
            end else if (instr_req_i) begin
               sel_valid = 1'b1;
               sel       = SRC_INSTR;
            end else if (data_req_i) begin
               sel_valid = 1'b1;
               sel       = SRC_DATA;
            end
         end
         HOLD: begin
            // Owner is locked in; a dropped request abandons the attempt.
            sel       = owner_q;
            sel_valid = (owner_q == SRC_INSTR) ? instr_req_i : data_req_i;
            if (!sel_valid) begin
               state_d = IDLE;
            end
         end
         RESP: begin
            if (mem_rvalid_i) begin
               resp_valid = 1'b1;
               resp_rdata = mem_rdata_i;
               state_d    = IDLE;
            end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
               resp_valid = 1'b1;
               resp_err   = 1'b1;
               resp_rdata = ERR_RDATA;
               state_d    = IDLE;
            end else begin
               wd_d = wd_q + TO_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (sel_valid) begin
         mem_req_o = 1'b1;
         if (sel == SRC_INSTR) begin
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i & 32'hFFFF_FFFC;
            instr_gnt_o = mem_gnt_i;
         end else begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i & 32'hFFFF_FFFC;
            mem_wdata_o = data_wdata_i;
            data_gnt_o  = mem_gnt_i;
         end
         owner_d = sel;
         if (mem_gnt_i) begin
            prefer_d = (sel == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
            wd_d     = '0;
            state_d  = RESP;
         end else begin
            state_d  = HOLD;
         end
      end

      if (resp_valid) begin
         if (owner_q == SRC_INSTR) begin
            instr_rvalid_o = 1'b1;
            instr_rdata_o  = resp_rdata;
            instr_err_o    = resp_err;
         end else begin
            data_rvalid_o  = 1'b1;
            data_rdata_o   = resp_rdata;
            data_err_o     = resp_err;
         end
      end

      // Outputs are quiet for the whole reset cycle, not just after the edge.
      if (rst_i) begin
         mem_req_o      = 1'b0;
         mem_we_o       = 1'b0;
         mem_be_o       = '0;
         mem_addr_o     = '0;
         mem_wdata_o    = '0;
         instr_gnt_o    = 1'b0;
         data_gnt_o     = 1'b0;
         instr_rvalid_o = 1'b0;
         instr_rdata_o  = '0;
         instr_err_o    = 1'b0;
         data_rvalid_o  = 1'b0;
         data_rdata_o   = '0;
         data_err_o     = 1'b0;
      end
   end

   assign busy_o = (state_q != IDLE) && !rst_i;

endmodule

// File: tb/tb_flexbex_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_flexbex_mem_arbiter
//
// Directed scenarios with literal expectations, followed by randomized
// requesters and a randomly granting / responding memory. A transaction-level
// model (pending owner, in-flight owner, age since grant, round-robin
// preference) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_flexbex_mem_arbiter;

   localparam int unsigned T_CYC = 4;
   localparam logic [31:0] ERR_D = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i, data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic        data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   flexbex_mem_arbiter #(
      .TIMEOUT_CYCLES(T_CYC),
      .TO_WIDTH      (4),
      .ERR_RDATA     (ERR_D)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .instr_req_i   (instr_req_i),
      .instr_addr_i  (instr_addr_i),
      .instr_gnt_o   (instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o),
      .instr_rdata_o (instr_rdata_o),
      .instr_err_o   (instr_err_o),
      .data_req_i    (data_req_i),
      .data_we_i     (data_we_i),
      .data_be_i     (data_be_i),
      .data_addr_i   (data_addr_i),
      .data_wdata_i  (data_wdata_i),
      .data_gnt_o    (data_gnt_o),
      .data_rvalid_o (data_rvalid_o),
      .data_rdata_o  (data_rdata_o),
      .data_err_o    (data_err_o),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .mem_be_o      (mem_be_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .busy_o        (busy_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // m_lock : requester stuck waiting for a grant (-1 none)
   // m_wait : a granted transaction awaits its response, owned by m_owner
   // m_age  : cycles elapsed since that grant
   int   m_lock   = -1;
   bit   m_wait   = 1'b0;
   int   m_owner  = 0;
   int   m_age    = 0;
   int   m_prefer = 0;
   bit   s_rst    = 1'b1;
   bit   s_resp   = 1'b0;
   bit   s_gnt    = 1'b0;
   int   s_cand   = -1;

   logic        e_mreq, e_we, e_igt, e_dgt, e_irv, e_drv, e_ierr, e_derr, e_busy;
   logic [3:0]  e_be;
   logic [31:0] e_addr, e_wdata, e_ird, e_drd;

   always @(negedge clk) begin
      int   cand;
      bit   fire;
      logic err;
      logic [31:0] rd;
      cand = -1; fire = 1'b0; err = 1'b0; rd = '0;
      e_mreq = 0; e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
      e_igt = 0; e_dgt = 0; e_irv = 0; e_drv = 0; e_ierr = 0; e_derr = 0;
      e_ird = 0; e_drd = 0; e_busy = 0;
      if (!rst_i) begin
         e_busy = (m_lock >= 0) || m_wait;
         if (m_wait) begin
            if (mem_rvalid_i) begin
               fire = 1'b1; rd = mem_rdata_i;
            end else if (T_CYC != 0 && m_age == int'(T_CYC)) begin
               fire = 1'b1; err = 1'b1; rd = ERR_D;
            end
            if (fire && m_owner == 0) begin e_irv = 1; e_ierr = err; e_ird = rd; end
            if (fire && m_owner == 1) begin e_drv = 1; e_derr = err; e_drd = rd; end
         end else begin
            if (m_lock == 0)      cand = instr_req_i ? 0 : -1;
            else if (m_lock == 1) cand = data_req_i ? 1 : -1;
            else if (instr_req_i && data_req_i) cand = m_prefer;
            else if (instr_req_i) cand = 0;
            else if (data_req_i)  cand = 1;
            if (cand == 0) begin
               e_mreq = 1; e_be = 4'hF; e_addr = {instr_addr_i[31:2], 2'b00};
               e_igt = mem_gnt_i;
            end else if (cand == 1) begin
               e_mreq = 1; e_we = data_we_i; e_be = data_be_i; e_wdata = data_wdata_i;
               e_addr = {data_addr_i[31:2], 2'b00};
               e_dgt = mem_gnt_i;
            end
         end
      end
      chk("mem_req", mem_req_o, e_mreq);
      if (e_mreq || rst_i) begin
         chk("mem_we", mem_we_o, e_we);
         chk("mem_be", mem_be_o, e_be);
         chk("mem_addr", mem_addr_o, e_addr);
         chk("mem_wdata", mem_wdata_o, e_wdata);
      end
      chk("instr_gnt", instr_gnt_o, e_igt);
      chk("data_gnt", data_gnt_o, e_dgt);
      chk("instr_rvalid", instr_rvalid_o, e_irv);
      chk("instr_err", instr_err_o, e_ierr);
      chk("instr_rdata", instr_rdata_o, e_ird);
      chk("data_rvalid", data_rvalid_o, e_drv);
      chk("data_err", data_err_o, e_derr);
      chk("data_rdata", data_rdata_o, e_drd);
      chk("busy", busy_o, e_busy);
      s_rst  = rst_i;
      s_resp = fire;
      s_cand = cand;
      s_gnt  = (cand >= 0) && mem_gnt_i;
   end

   always @(posedge clk) begin
      if (s_rst) begin
         m_lock = -1; m_wait = 0; m_prefer = 0; m_age = 0;
      end else if (m_wait) begin
         if (s_resp) m_wait = 0;
         else        m_age++;
      end else if (s_gnt) begin
         m_wait   = 1;
         m_age    = 1;
         m_owner  = s_cand;
         m_prefer = 1 - s_cand;
         m_lock   = -1;
      end else begin
         m_lock = s_cand;
      end
   end

   // ---------------- stimulus ----------------
   logic ig, dg;

   initial begin
      rst_i = 1; instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 0;
      instr_addr_i = 32'h2006; data_addr_i = 32'h1003; data_be_i = 4'b1000;
      data_we_i = 1; data_wdata_i = 32'hA500_0000; mem_rdata_i = 32'h0;
      #1;

      // Reset with both requests and a granting memory: everything quiet.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("d_rst_mem_req", mem_req_o, 0);
         chk("d_rst_igt", instr_gnt_o, 0);
         chk("d_rst_dgt", data_gnt_o, 0);
         chk("d_rst_busy", busy_o, 0);
         tick();
      end

      // First arbitration after reset favours the fetch port.
      rst_i = 0;
      @(negedge clk);
      chk("d_first_igt", instr_gnt_o, 1);
      chk("d_first_dgt", data_gnt_o, 0);
      chk("d_fetch_addr", mem_addr_o, 32'h2004);
      chk("d_fetch_be", mem_be_o, 4'hF);
      chk("d_fetch_we", mem_we_o, 0);
      tick();
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1111_1111;
      @(negedge clk);
      chk("d_rr1_irv", instr_rvalid_o, 1);
      chk("d_rr1_ird", instr_rdata_o, 32'h1111_1111);
      chk("d_rr1_drv", data_rvalid_o, 0);
      chk("d_rr1_busy", busy_o, 1);
      tick();

      // Second grant goes to data: aligned write forwarding.
      mem_rvalid_i = 0; mem_gnt_i = 1;
      @(negedge clk);
      chk("d_rr2_dgt", data_gnt_o, 1);
      chk("d_rr2_igt", instr_gnt_o, 0);
      chk("d_wr_addr", mem_addr_o, 32'h1000);
      chk("d_wr_be", mem_be_o, 4'b1000);
      chk("d_wr_we", mem_we_o, 1);
      chk("d_wr_wdata", mem_wdata_o, 32'hA500_0000);
      tick();
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h2222_2222;
      @(negedge clk);
      chk("d_rr2_drv", data_rvalid_o, 1);
      chk("d_rr2_drd", data_rdata_o, 32'h2222_2222);
      chk("d_rr2_irv", instr_rvalid_o, 0);
      tick();
      mem_rvalid_i = 0; mem_gnt_i = 1;
      @(negedge clk);
      chk("d_rr3_igt", instr_gnt_o, 1);
      chk("d_rr3_dgt", data_gnt_o, 0);
      tick();
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h3333_3333;
      @(negedge clk);
      chk("d_rr3_irv", instr_rvalid_o, 1);
      tick();

      // Grant stall on a data request; fetch request joins and must wait.
      mem_rvalid_i = 0; instr_req_i = 0; data_req_i = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("d_stall_dgt", data_gnt_o, 0);
         chk("d_stall_igt", instr_gnt_o, 0);
         chk("d_stall_addr", mem_addr_o, 32'h1000);
         if (k > 0) chk("d_stall_busy", busy_o, 1);
         tick();
         instr_req_i = 1;
      end
      mem_gnt_i = 1;
      @(negedge clk);
      chk("d_stall_dgt_end", data_gnt_o, 1);
      chk("d_stall_igt_end", instr_gnt_o, 0);
      tick();
      mem_gnt_i = 0; data_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h4444_4444;
      @(negedge clk);
      chk("d_stall_drv", data_rvalid_o, 1);
      chk("d_stall_drd", data_rdata_o, 32'h4444_4444);
      tick();

      // Fetch served next, then memory never answers: watchdog error.
      mem_rvalid_i = 0; mem_gnt_i = 1;
      @(negedge clk);
      chk("d_wd_igt", instr_gnt_o, 1);
      tick();
      instr_req_i = 0; mem_gnt_i = 0;
      for (int k = 1; k < int'(T_CYC); k++) begin
         @(negedge clk);
         chk("d_wd_wait_irv", instr_rvalid_o, 0);
         tick();
      end
      @(negedge clk);
      chk("d_wd_irv", instr_rvalid_o, 1);
      chk("d_wd_ierr", instr_err_o, 1);
      chk("d_wd_ird", instr_rdata_o, 32'hDEADBEEF);
      tick();
      mem_rvalid_i = 1; mem_rdata_i = 32'h5555_5555;
      @(negedge clk);
      chk("d_stray_irv", instr_rvalid_o, 0);
      chk("d_stray_drv", data_rvalid_o, 0);
      chk("d_stray_busy", busy_o, 0);
      tick();

      // Reset in the middle of a response wait abandons the transaction.
      mem_rvalid_i = 0; instr_req_i = 1; mem_gnt_i = 1;
      @(negedge clk);
      chk("d_mid_igt", instr_gnt_o, 1);
      tick();
      rst_i = 1; instr_req_i = 0; mem_gnt_i = 0;
      @(negedge clk);
      chk("d_mid_rst_busy", busy_o, 0);
      tick();
      rst_i = 0; mem_rvalid_i = 1;
      @(negedge clk);
      chk("d_mid_irv", instr_rvalid_o, 0);
      chk("d_mid_drv", data_rvalid_o, 0);
      chk("d_mid_busy", busy_o, 0);
      tick();
      mem_rvalid_i = 0;

      // Randomized traffic; requesters hold their fields until granted.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         ig = instr_gnt_o;
         dg = data_gnt_o;
         tick();
         rst_i = ($urandom_range(0, 199) == 0);
         if (!instr_req_i || ig) begin
            instr_req_i  = $urandom_range(0, 1);
            instr_addr_i = $urandom;
         end else if ($urandom_range(0, 49) == 0) begin
            instr_req_i = 0;
         end
         if (!data_req_i || dg) begin
            data_req_i   = $urandom_range(0, 1);
            data_addr_i  = $urandom;
            data_we_i    = $urandom_range(0, 1);
            data_be_i    = 4'($urandom);
            data_wdata_i = $urandom;
         end else if ($urandom_range(0, 49) == 0) begin
            data_req_i = 0;
         end
         mem_gnt_i    = ($urandom_range(0, 9) < 6);
         mem_rvalid_i = ($urandom_range(0, 9) < 3);
         mem_rdata_i  = $urandom;
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
